note_tone_gen: RTL and testbench

Square-wave tone generator directly downstream of the PS/2 key-to-note decoder. It consumes the decoder's note code (1–13, 0 = no event) and octave (1–5), and latches a note on every non-zero note code. It then drives a 1-bit square wave at that pitch for a fixed duration and feeds the board's audio output pin.

---
 rtl/tone_pkg.sv | 50 +++++
 rtl/tone_period_rom.sv | 30 +++
 rtl/note_tone_gen.sv | 158 +++++++++++++++
 tb/tb_note_tone_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared constants, state enum and pitch helpers for note_tone_gen
// Contents: note range / octave range constants, HALF_W (half-period width),
// tone_state_e {IDLE, PLAY}, note_chz() (note frequency in centi-Hz) and
// base_half() (octave-1 half period in clock cycles, rounded).
package tone_pkg;

    localparam int NOTE_MIN = 1;
    localparam int NOTE_MAX = 13;
    localparam int OCT_MIN  = 1;
    localparam int OCT_MAX  = 5;
    localparam int HALF_W   = 20;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } tone_state_e;

    // C3..C4 chromatic, 130.81 Hz * 2^((n-1)/12), in hundredths of a Hz.
    function automatic longint note_chz(input logic [3:0] n);
        case (n)
            4'd1:    return 13081;
            4'd2:    return 13859;
            4'd3:    return 14683;
            4'd4:    return 15556;
            4'd5:    return 16481;
            4'd6:    return 17461;
            4'd7:    return 18500;
            4'd8:    return 19600;
            4'd9:    return 20765;
            4'd10:   return 22000;
            4'd11:   return 23308;
            4'd12:   return 24694;
            4'd13:   return 26162;
            default: return 0;
        endcase
    endfunction

    // round(clk_hz / (2 * f)) with f in centi-Hz: (clk_hz*100 + fc) / (2*fc).
    function automatic logic [HALF_W-1:0] base_half(input longint clk_hz, input logic [3:0] n);
        longint fc;
        longint q;
        fc = note_chz(n);
        if (fc == 0) begin
            return '0;
        end
        q = (clk_hz * 100 + fc) / (2 * fc);
        return q[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/tone_period_rom.sv
// rtl/tone_period_rom.sv - combinational (note, octave) to half-period map
// Ports: note (4b note code), octave (3b, out-of-range values act as 1),
// half_period (20b cycles per audio half period).
module tone_period_rom
    import tone_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic [3:0]        note,
    input  logic [2:0]        octave,
    output logic [HALF_W-1:0] half_period
);

    // Table built at elaboration; only the shifter is real logic.
    logic [HALF_W-1:0] base_tbl [16];
    logic [2:0]        shift;

    for (genvar i = 0; i < 16; i++) begin : g_tbl
        assign base_tbl[i] = base_half(longint'(CLK_HZ), 4'(i));
    end

    always_comb begin
        shift = 3'd0;
        if (octave >= 3'(OCT_MIN) && octave <= 3'(OCT_MAX)) begin
            shift = octave - 3'(OCT_MIN);
        end
        half_period = base_tbl[note] >> shift;
    end

endmodule

// File: rtl/note_tone_gen.sv
// rtl/note_tone_gen.sv - square-wave note generator with fixed note duration
// Ports: clock, rst (sync, active-low), teclita (note code, 1..13 triggers),
// octava (octave 1..5), audio (registered tone), playing, note_q (latched note).
// Optional macro TONE_DECAY_EN: amplitude decay with PWM gating of audio.
module note_tone_gen
    import tone_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int NOTE_CYCLES = 50_000_000,
    parameter int DECAY_DIV   = 196_078
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [3:0] teclita,
    input  logic [2:0] octava,
    output logic       audio,
    output logic       playing,
    output logic [3:0] note_q
);

    localparam int              DUR_W    = $clog2(NOTE_CYCLES + 1);
    localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_CYCLES - 1);

    tone_state_e       state_q, state_d;
    logic [3:0]        note_d;
    logic [HALF_W-1:0] half_q, half_d, rom_half;
    logic [HALF_W-1:0] phase_q, phase_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              square_q, square_d;
    logic              playing_d, audio_d;
    logic              trigger;

`ifdef TONE_DECAY_EN
    localparam int              DEC_W    = $clog2(DECAY_DIV + 1);
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_DIV - 1);

    logic [7:0]       amp_q, amp_d;
    logic [7:0]       pwm_q, pwm_d;
    logic [DEC_W-1:0] dec_q, dec_d;
`endif

    tone_period_rom #(.CLK_HZ(CLK_HZ)) u_rom (
        .note        (teclita),
        .octave      (octava),
        .half_period (rom_half)
    );

    assign trigger = (teclita >= 4'(NOTE_MIN)) && (teclita <= 4'(NOTE_MAX));

    always_comb begin
        state_d  = state_q;
        note_d   = note_q;
        half_d   = half_q;
        phase_d  = phase_q;
        dur_d    = dur_q;
        square_d = square_q;
`ifdef TONE_DECAY_EN
        amp_d    = amp_q;
        dec_d    = dec_q;
        pwm_d    = pwm_q + 8'd1;
`endif
        // A trigger takes priority over expiry, so it is checked first.
        if (trigger) begin
            state_d  = PLAY;
            note_d   = teclita;
            half_d   = rom_half;
            phase_d  = '0;
            dur_d    = '0;
            square_d = 1'b0;
`ifdef TONE_DECAY_EN
            amp_d    = 8'd255;
            dec_d    = '0;
`endif
        end else if (state_q == PLAY) begin
            if (dur_q == DUR_LAST) begin
                state_d  = IDLE;
                note_d   = '0;
                half_d   = '0;
                phase_d  = '0;
                dur_d    = '0;
                square_d = 1'b0;
`ifdef TONE_DECAY_EN
                amp_d    = '0;
                dec_d    = '0;
`endif
            end else begin
                dur_d = dur_q + 1'b1;
                if (phase_q == half_q - 1'b1) begin
                    phase_d  = '0;
                    square_d = ~square_q;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
`ifdef TONE_DECAY_EN
                if (dec_q == DEC_LAST) begin
                    dec_d = '0;
                    if (amp_q != 8'd0) begin
                        amp_d = amp_q - 8'd1;
                    end
                end else begin
                    dec_d = dec_q + 1'b1;
                end
`endif
            end
        end else begin
            note_d   = '0;
            half_d   = '0;
            phase_d  = '0;
            dur_d    = '0;
            square_d = 1'b0;
`ifdef TONE_DECAY_EN
            amp_d    = '0;
            dec_d    = '0;
`endif
        end

        playing_d = (state_d == PLAY);
`ifdef TONE_DECAY_EN
        // Gate with the next-cycle PWM/amplitude so audio lines up with square.
        audio_d = square_d & (pwm_d < amp_d);
`else
        audio_d = square_d;
`endif
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q  <= IDLE;
            note_q   <= '0;
            half_q   <= '0;
            phase_q  <= '0;
            dur_q    <= '0;
            square_q <= 1'b0;
            playing  <= 1'b0;
            audio    <= 1'b0;
`ifdef TONE_DECAY_EN
            amp_q    <= '0;
            dec_q    <= '0;
            pwm_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            half_q   <= half_d;
            phase_q  <= phase_d;
            dur_q    <= dur_d;
            square_q <= square_d;
            playing  <= playing_d;
            audio    <= audio_d;
`ifdef TONE_DECAY_EN
            amp_q    <= amp_d;
            dec_q    <= dec_d;
            pwm_q    <= pwm_d;
`endif
        end
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// tb/tb_note_tone_gen.sv - directed self-checking bench for note_tone_gen
module tb_note_tone_gen;

    localparam int CLK_HZ = 100_000;
`ifdef TONE_DECAY_EN
    localparam int NC = 2000;
`else
    localparam int NC = 1000;
`endif
    localparam int DDIV = 4;

    // Half periods at 100 kHz: note1=382, note7=270, note10=227, note13=191.
    localparam int H_N1  = 382;
    localparam int H_N10 = 227;
    localparam int H_N13 = 191;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] teclita = 4'd0;
    logic [2:0] octava = 3'd1;
    logic       audio;
    logic       playing;
    logic [3:0] note_q;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    note_tone_gen #(
        .CLK_HZ      (CLK_HZ),
        .NOTE_CYCLES (NC),
        .DECAY_DIV   (DDIV)
    ) dut (
        .clock   (clock),
        .rst     (rst),
        .teclita (teclita),
        .octava  (octava),
        .audio   (audio),
        .playing (playing),
        .note_q  (note_q)
    );

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic trigger(input logic [3:0] n, input logic [2:0] o);
        teclita = n;
        octava  = o;
        step();
        teclita = 4'd0;
    endtask

    // Observes ncyc cycles after a trigger edge (index 0 = trigger edge).
    task automatic watch(input int ncyc, output int rise1, output int rise2, output int plays);
        logic prev;
        rise1 = -1;
        rise2 = -1;
        plays = playing ? 1 : 0;
        prev  = audio;
        for (int j = 1; j <= ncyc; j++) begin
            step();
            if (playing) plays++;
            if (audio && !prev) begin
                if (rise1 < 0) rise1 = j;
                else if (rise2 < 0) rise2 = j;
            end
            prev = audio;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        teclita = 4'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (audio !== 1'b0) begin bad++; $display("FAIL reset_audio: got %0b want 0", audio); end
            total++;
            if (playing !== 1'b0) begin bad++; $display("FAIL reset_playing: got %0b want 0", playing); end
            total++;
            if (note_q !== 4'd0) begin bad++; $display("FAIL reset_note: got %0d want 0", note_q); end
        end
        teclita = 4'd0;
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int r1, r2, p;
        trigger(4'd10, 3'd1);
        total++;
        if (note_q !== 4'd10) begin bad++; $display("FAIL basic_note: got %0d want 10", note_q); end
        total++;
        if (playing !== 1'b1) begin bad++; $display("FAIL basic_playing: got %0b want 1", playing); end
        total++;
        if (audio !== 1'b0) begin bad++; $display("FAIL basic_audio0: got %0b want 0", audio); end
        watch(NC + 10, r1, r2, p);
`ifndef TONE_DECAY_EN
        total++;
        if (r1 !== H_N10) begin bad++; $display("FAIL basic_rise1: got %0d want %0d", r1, H_N10); end
        total++;
        if (r2 !== 3 * H_N10) begin bad++; $display("FAIL basic_rise2: got %0d want %0d", r2, 3 * H_N10); end
`endif
        total++;
        if (p !== NC) begin bad++; $display("FAIL basic_duration: got %0d want %0d", p, NC); end
        total++;
        if (note_q !== 4'd0) begin bad++; $display("FAIL basic_idle_note: got %0d want 0", note_q); end
        total++;
        if (audio !== 1'b0) begin bad++; $display("FAIL basic_idle_audio: got %0b want 0", audio); end
    endtask

    task automatic test_octave();
        int r1, r2, p;
        int exp2;
        trigger(4'd1, 3'd3);
        octava = 3'd5;  // must not change the sounding pitch
        watch(NC + 5, r1, r2, p);
`ifndef TONE_DECAY_EN
        total++;
        if (r1 !== H_N1 / 4) begin bad++; $display("FAIL oct3_rise1: got %0d want %0d", r1, H_N1 / 4); end
        total++;
        if (r2 !== 3 * (H_N1 / 4)) begin bad++; $display("FAIL oct3_rise2: got %0d want %0d", r2, 3 * (H_N1 / 4)); end
`endif
        total++;
        if (p !== NC) begin bad++; $display("FAIL oct3_duration: got %0d want %0d", p, NC); end
        trigger(4'd1, 3'd7);
        watch(NC + 5, r1, r2, p);
        exp2 = (3 * H_N1 < NC) ? 3 * H_N1 : -1;
`ifndef TONE_DECAY_EN
        total++;
        if (r1 !== H_N1) begin bad++; $display("FAIL oct7_rise1: got %0d want %0d", r1, H_N1); end
        total++;
        if (r2 !== exp2) begin bad++; $display("FAIL oct7_rise2: got %0d want %0d", r2, exp2); end
`endif
        total++;
        if (p !== NC) begin bad++; $display("FAIL oct7_duration: got %0d want %0d", p, NC); end
    endtask

    task automatic test_retrigger();
        int r1, r2, p;
        trigger(4'd1, 3'd1);
        for (int j = 1; j < 500; j++) step();
`ifndef TONE_DECAY_EN
        total++;
        if (audio !== 1'b1) begin bad++; $display("FAIL retrig_pre_audio: got %0b want 1", audio); end
`endif
        trigger(4'd13, 3'd1);
        total++;
        if (note_q !== 4'd13) begin bad++; $display("FAIL retrig_note: got %0d want 13", note_q); end
        total++;
        if (audio !== 1'b0) begin bad++; $display("FAIL retrig_audio: got %0b want 0", audio); end
        total++;
        if (playing !== 1'b1) begin bad++; $display("FAIL retrig_playing: got %0b want 1", playing); end
        watch(NC + 5, r1, r2, p);
`ifndef TONE_DECAY_EN
        total++;
        if (r1 !== H_N13) begin bad++; $display("FAIL retrig_rise1: got %0d want %0d", r1, H_N13); end
`endif
        total++;
        if (p !== NC) begin bad++; $display("FAIL retrig_duration: got %0d want %0d", p, NC); end
    endtask

    task automatic test_expiry_tie();
        int r1, r2, p;
        trigger(4'd7, 3'd1);
        for (int j = 1; j < NC; j++) step();
        total++;
        if (playing !== 1'b1) begin bad++; $display("FAIL tie_last_cycle: got %0b want 1", playing); end
        trigger(4'd5, 3'd2);
        total++;
        if (playing !== 1'b1) begin bad++; $display("FAIL tie_playing: got %0b want 1", playing); end
        total++;
        if (note_q !== 4'd5) begin bad++; $display("FAIL tie_note: got %0d want 5", note_q); end
        watch(NC + 5, r1, r2, p);
        total++;
        if (p !== NC) begin bad++; $display("FAIL tie_duration: got %0d want %0d", p, NC); end
    endtask

    task automatic test_invalid();
        for (int k = 14; k <= 15; k++) begin
            teclita = 4'(k);
            for (int i = 0; i < 3; i++) begin
                step();
                total++;
                if (playing !== 1'b0) begin bad++; $display("FAIL invalid_%0d_playing: got %0b want 0", k, playing); end
                total++;
                if (note_q !== 4'd0) begin bad++; $display("FAIL invalid_%0d_note: got %0d want 0", k, note_q); end
            end
        end
        teclita = 4'd0;
        step();
    endtask

    task automatic test_reset_mid_note();
        trigger(4'd10, 3'd1);
        for (int j = 1; j <= 300; j++) step();
`ifndef TONE_DECAY_EN
        total++;
        if (audio !== 1'b1) begin bad++; $display("FAIL rstmid_pre_audio: got %0b want 1", audio); end
`endif
        rst = 1'b0;
        step();
        total++;
        if (audio !== 1'b0) begin bad++; $display("FAIL rstmid_audio: got %0b want 0", audio); end
        total++;
        if (playing !== 1'b0) begin bad++; $display("FAIL rstmid_playing: got %0b want 0", playing); end
        total++;
        if (note_q !== 4'd0) begin bad++; $display("FAIL rstmid_note: got %0d want 0", note_q); end
        rst = 1'b1;
        step();
        total++;
        if (playing !== 1'b0) begin bad++; $display("FAIL rstmid_after: got %0b want 0", playing); end
    endtask

`ifdef TONE_DECAY_EN
    task automatic test_decay();
        int highs_early;
        int highs_late;
        // note 13, octave 5: half period 191 >> 4 = 11 cycles
        trigger(4'd13, 3'd5);
        highs_early = 0;
        highs_late  = 0;
        for (int j = 1; j < NC; j++) begin
            step();
            if (j <= 200 && audio) highs_early++;
            if (j >= 255 * DDIV && audio) highs_late++;
        end
        total++;
        if (highs_early == 0) begin bad++; $display("FAIL decay_early_high: got %0d want >0", highs_early); end
        total++;
        if (highs_late !== 0) begin bad++; $display("FAIL decay_silent: got %0d want 0", highs_late); end
        step();
        total++;
        if (playing !== 1'b0) begin bad++; $display("FAIL decay_end: got %0b want 0", playing); end
    endtask
`endif

    initial begin
        @(negedge clock);
        test_reset();
        test_basic();
        test_octave();
        test_retrigger();
        test_expiry_tie();
        test_invalid();
        test_reset_mid_note();
`ifdef TONE_DECAY_EN
        test_decay();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
